// File: rtl/marquee_scroller.sv
// Scrolling marquee: streams a writable message through an external char ROM into a
// left-shifting row of NUM_DIGITS segment patterns, then flushes blanks (single pass or loop).
module marquee_scroller #(
  parameter int               NUM_DIGITS = 4,
  parameter int               SEG_W      = 16,
  parameter int               MSG_DEPTH  = 64,
  parameter int               PRESCALE   = 8388608,
  parameter logic [SEG_W-1:0] BLANK_SEG  = 16'hFFFF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0]      wr_addr,
  input  logic [7:0]                        wr_data,
  input  logic [$clog2(MSG_DEPTH+1)-1:0]    msg_len,
  input  logic                              loop_en,
  input  logic                              start,
  input  logic                              stop,
  output logic [7:0]                        rom_ascii,
  input  logic [SEG_W-1:0]                  rom_segments,
  output logic [NUM_DIGITS*SEG_W-1:0]       seg_out,
  output logic                              busy,
  output logic                              wrap
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = $clog2(MSG_DEPTH+1);
  localparam int CW = $clog2(PRESCALE);
  localparam int FW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = NUM_DIGITS*SEG_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [7:0]    mem_q [MSG_DEPTH];
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic          loop_q, loop_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [7:0]    rom_ascii_q, rom_ascii_d;
  logic          wrap_q, wrap_d;
  logic          counting;
  logic          tick;
  logic          last_char;

  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] cur,
                                             input logic [SEG_W-1:0] nxt);
    logic [DW-1:0] res;
    res = cur;
    for (int k = 0; k < NUM_DIGITS-1; k++) begin
      res[k*SEG_W +: SEG_W] = cur[(k+1)*SEG_W +: SEG_W];
    end
    res[(NUM_DIGITS-1)*SEG_W +: SEG_W] = nxt;
    return res;
  endfunction

  // The buffer has no reset; it may be rewritten at any time, even mid-scroll.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < MSG_DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign counting  = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign tick      = counting && (cnt_q == CW'(PRESCALE-1));
  assign last_char = (LW'(idx_q) == (len_q - LW'(1)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    len_d       = len_q;
    loop_d      = loop_q;
    flush_d     = flush_q;
    disp_d      = disp_q;
    rom_ascii_d = rom_ascii_q;
    wrap_d      = 1'b0;

    if (counting) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop && (msg_len != '0)) begin
          len_d   = (int'(msg_len) > MSG_DEPTH) ? LW'(MSG_DEPTH) : msg_len;
          loop_d  = loop_en;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (tick) begin
          rom_ascii_d = mem_q[idx_q];
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        disp_d = shift_in(disp_q, rom_segments);
        if (last_char) begin
          flush_d = '0;
          state_d = S_FLUSH;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_RUN;
        end
      end
      default: begin
        if (tick) begin
          disp_d = shift_in(disp_q, BLANK_SEG);
          if (flush_q == FW'(NUM_DIGITS-1)) begin
            flush_d = '0;
            if (loop_q) begin
              idx_d   = '0;
              wrap_d  = 1'b1;
              state_d = S_RUN;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            flush_d = flush_q + FW'(1);
          end
        end
      end
    endcase

    // Abort wins over everything else, including a shift due this cycle.
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      disp_d  = {NUM_DIGITS{BLANK_SEG}};
      wrap_d  = 1'b0;
    end

    if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      flush_q     <= '0;
      disp_q      <= {NUM_DIGITS{BLANK_SEG}};
      rom_ascii_q <= 8'h20;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      flush_q     <= flush_d;
      disp_q      <= disp_d;
      rom_ascii_q <= rom_ascii_d;
      wrap_q      <= wrap_d;
    end
  end

  assign rom_ascii = rom_ascii_q;
  assign seg_out   = disp_q;
  assign busy      = (state_q != S_IDLE);
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_marquee_scroller.sv
// Scoreboard bench: stimulus predicts display snapshots, wrap pulses and busy edges;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_marquee_scroller;
  localparam int ND = 4;
  localparam int SW = 16;
  localparam int MD = 64;
  localparam int PS = 4;
  localparam logic [15:0] BLK     = 16'hFFFF;
  localparam logic [63:0] ALL_BLK = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int EV_SHIFT = 0;
  localparam int EV_WRAP  = 1;
  localparam int EV_BUSY  = 2;

  typedef struct {
    int          kind;
    logic [63:0] seg;
    int          gap;
    logic        bval;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [6:0]  msg_len = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  rom_ascii;
  logic [15:0] rom_segments;
  logic [63:0] seg_out;
  logic        busy;
  logic        wrap;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_shift_cyc = 0;
  bit mon_en = 1'b0;
  ev_t exp_q[$];
  logic [15:0] mdisp [ND];
  logic [7:0]  mbuf [MD];
  logic [63:0] prev_seg;
  logic        prev_busy;
  ev_t         mon_e;
  bit          mon_ok;

  marquee_scroller #(.NUM_DIGITS(ND), .SEG_W(SW), .MSG_DEPTH(MD), .PRESCALE(PS), .BLANK_SEG(BLK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .loop_en(loop_en), .start(start), .stop(stop),
    .rom_ascii(rom_ascii), .rom_segments(rom_segments), .seg_out(seg_out),
    .busy(busy), .wrap(wrap)
  );

  assign rom_segments = {8'h00, rom_ascii};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic take(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e = '{kind: -1, seg: '0, gap: 0, bval: 1'b0};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind %0d, required no event", kind);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        failures++;
        $display("FAIL event_order: got kind %0d, required kind %0d", kind, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (seg_out !== prev_seg) begin
          take(EV_SHIFT, mon_e, mon_ok);
          if (mon_ok) begin
            chk("display", seg_out, mon_e.seg);
            if (mon_e.gap != 0) chk("shift_gap", 64'(cyc - last_shift_cyc), 64'(mon_e.gap));
          end
          last_shift_cyc = cyc;
        end
        if (wrap === 1'b1) take(EV_WRAP, mon_e, mon_ok);
        if (busy !== prev_busy) begin
          take(EV_BUSY, mon_e, mon_ok);
          if (mon_ok) chk("busy_edge", 64'(busy), 64'(mon_e.bval));
        end
      end
      prev_seg  = seg_out;
      prev_busy = busy;
    end
  end

  // Reference model: a plain array of digits, one shift per displayed character or blank.
  function automatic logic [63:0] mpack();
    logic [63:0] v;
    for (int k = 0; k < ND; k++) v[k*16 +: 16] = mdisp[k];
    return v;
  endfunction

  task automatic m_push(input int kind, input logic [63:0] seg, input int gap, input logic bval);
    exp_q.push_back('{kind: kind, seg: seg, gap: gap, bval: bval});
  endtask

  task automatic m_shift(input logic [15:0] v, input int gap);
    for (int k = 0; k < ND-1; k++) mdisp[k] = mdisp[k+1];
    mdisp[ND-1] = v;
    m_push(EV_SHIFT, mpack(), gap, 1'b0);
  endtask

  task automatic m_pass(input int len);
    for (int i = 0; i < len; i++) m_shift({8'h00, mbuf[i]}, PS + 1);
    for (int j = 0; j < ND; j++) m_shift(BLK, PS);
  endtask

  task automatic m_stop();
    if (mpack() !== ALL_BLK) begin
      for (int k = 0; k < ND; k++) mdisp[k] = BLK;
      m_push(EV_SHIFT, ALL_BLK, 0, 1'b0);
    end
    m_push(EV_BUSY, '0, 0, 1'b0);
  endtask

  function automatic logic [7:0] rand_char(input logic [7:0] a1, input logic [7:0] a2);
    logic [7:0] c;
    do c = 8'h41 + 8'($urandom_range(25, 0)); while (c == a1 || c == a2);
    return c;
  endfunction

  task automatic wbuf(input int a, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = c;
    mbuf[a] = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int len, input bit lp, input bit accepted);
    start = 1'b1; msg_len = 7'(len); loop_en = lp;
    if (accepted) last_shift_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_q(input int max_left, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() <= max_left) break;
      @(negedge clk);
    end
    chk(name, 64'(exp_q.size() <= max_left), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [7:0] newc;
    for (int k = 0; k < ND; k++) mdisp[k] = BLK;

    // Reset, with a start pulse that must be overridden.
    repeat (1) @(negedge clk);
    start = 1'b1; msg_len = 7'd2;
    @(negedge clk);
    start = 1'b0;
    chk("rst_seg", seg_out, ALL_BLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wrap", 64'(wrap), 64'd0);
    chk("rst_rom_ascii", 64'(rom_ascii), 64'h20);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    mon_en = 1'b1;

    // Zero length and simultaneous start/stop in IDLE do nothing.
    pulse_start(0, 1'b0, 1'b0);
    start = 1'b1; stop = 1'b1; msg_len = 7'd3;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("zero_len_busy", 64'(busy), 64'd0);

    // Single pass "HI"; a second start while busy must be ignored.
    wbuf(0, 8'h48);
    wbuf(1, 8'h49);
    m_push(EV_BUSY, '0, 0, 1'b1);
    m_pass(2);
    m_push(EV_BUSY, '0, 0, 1'b0);
    pulse_start(2, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    pulse_start(5, 1'b1, 1'b0);
    wait_q(0, 200, "single_pass_drain");
    chk("single_pass_idle", 64'(busy), 64'd0);

    // Looping "ABC": two full passes, the first char of the third, then stop.
    wbuf(0, 8'h41); wbuf(1, 8'h42); wbuf(2, 8'h43);
    m_push(EV_BUSY, '0, 0, 1'b1);
    m_pass(3); m_push(EV_WRAP, '0, 0, 1'b0);
    m_pass(3); m_push(EV_WRAP, '0, 0, 1'b0);
    m_shift(16'h0041, PS + 1);
    pulse_start(3, 1'b1, 1'b1);
    wait_q(0, 300, "loop_drain");
    m_stop();
    pulse_stop();
    wait_q(0, 20, "loop_stop_drain");

    // Stop right after the second character lands, then restart from index 0.
    for (int i = 0; i < 5; i++) wbuf(i, rand_char(i > 0 ? mbuf[i-1] : 8'h00, 8'h00));
    m_push(EV_BUSY, '0, 0, 1'b1);
    m_shift({8'h00, mbuf[0]}, PS + 1);
    m_shift({8'h00, mbuf[1]}, PS + 1);
    pulse_start(5, 1'b0, 1'b1);
    wait_q(0, 100, "stop_run_drain");
    m_stop();
    pulse_stop();
    wait_q(0, 20, "stop_drain");
    chk("stop_busy", 64'(busy), 64'd0);
    m_push(EV_BUSY, '0, 0, 1'b1);
    m_pass(5);
    m_push(EV_BUSY, '0, 0, 1'b0);
    pulse_start(5, 1'b0, 1'b1);
    wait_q(0, 200, "restart_drain");

    // Length clamp to 64, with buf[2] rewritten while index 1 is pending.
    for (int i = 0; i < MD; i++) wbuf(i, rand_char(i > 0 ? mbuf[i-1] : 8'h00, 8'h00));
    newc = rand_char(mbuf[1], mbuf[3]);
    mbuf[2] = newc;
    m_push(EV_BUSY, '0, 0, 1'b1);
    m_pass(MD);
    m_push(EV_BUSY, '0, 0, 1'b0);
    pulse_start(100, 1'b0, 1'b1);
    wait_q(MD + ND, 20, "clamp_first_shift");
    wbuf(2, newc);
    wait_q(0, 1000, "clamp_drain");

    // Reset during the FETCH of the second character.
    mon_en = 1'b0;
    pulse_start(2, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (seg_out !== ALL_BLK) begin seen = 1'b1; break; end
    end
    chk("midrst_first_shift", 64'(seen), 64'd1);
    repeat (4) @(negedge clk);
    chk("midrst_fetch_ascii", 64'(rom_ascii), 64'(mbuf[1]));
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_seg", seg_out, ALL_BLK);
    chk("midrst_rom_ascii", 64'(rom_ascii), 64'h20);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wrap", 64'(wrap), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
